vga_fb_display: RTL
===================

# vga_fb_display

Pixel-fetch and colour-output stage placed directly downstream of the 640x480 VGA sync generator. It consumes the generator's pixel strobe, column/row counts, visible flag and raw syncs, and reads a double-buffered 320x240 RGB565 camera frame buffer through a 1-cycle synchronous-read RAM port. It upscales the frame 2x to 640x480, drives 4-bit-per-channel VGA colour, and delays hsync/vsync to match. Buffer swaps happen only at the start of vertical blanking, so the display never tears.

## Interface
- c_img_cols, 320, source image width in pixels
- c_img_rows, 240, source image height in lines
- c_line_visible, 480, visible display lines; swap point row value
- c_nb_pix_addr, 17, bits of in-buffer pixel index (ceil log2 of cols*rows)
- c_synch_act, 0, active level of hsync/vsync

Ports:
- clk  in  1  system clock, 50 MHz; pixel rate is clk/2
- rst  in  1  synchronous reset, active-low (rst=0 resets on clk edge)
- new_pxl  in  1  pixel strobe from sync generator; high every 2nd clk
- visible  in  1  col<640 and row<480
- hsync, vsync  in  1 each  raw syncs, aligned with col/row
- col, row  in  10 each  current pixel column/line
- wr_done  in  1  one-clk pulse: camera writer finished a frame in the back buffer
- rd_data  in  16  RGB565 from RAM, valid 1 clk after rd_addr/rd_en sampled
- rd_addr  out  c_nb_pix_addr+1  {disp_buf, pixel index}
- rd_en  out  1  RAM read enable
- wr_buf  out  1  buffer the writer may fill (= ~disp_buf)
- swap  out  1  one-clk pulse when disp_buf toggles
- vga_red, vga_green, vga_blue  out  4 each  colour
- vga_hsync, vga_vsync  out  1 each  delayed syncs

## Operation
- Reset values: rd_addr=0, rd_en=0, colours=0, vga_hsync=vga_vsync=~c_synch_act, disp_buf=0, wr_buf=1, pending=0, swap=0. Reset mid-frame flushes the pipeline: all outputs reach reset values at the first edge with rst=0.
- All pipeline registers advance only on edges where new_pxl=1.
- Stage 1, at the new_pxl edge for (col,row):
  - in_img = visible && (col>>1)<c_img_cols && (row>>1)<c_img_rows.
  - rd_en <= in_img.
  - rd_addr <= {disp_buf, (row>>1)*c_img_cols + (col>>1)}, truncated to c_nb_pix_addr bits. An incremental line-base counter is acceptable if results are identical.
  - hsync, vsync and in_img are captured into delay stage 1.
- Stage 2, at the next new_pxl edge:
  - If stage-1 in_img: red=rd_data[15:12], green=rd_data[10:7], blue=rd_data[4:1]. Otherwise colours=0.
  - Syncs move to the outputs.
- Buffer control:
  - wr_done sets pending.
  - The swap point is the new_pxl edge where row==c_line_visible and col==0.
  - At the swap point, if pending (or wr_done is high the same clk): disp_buf toggles, pending clears, swap=1 for that one clk.
  - A further wr_done while pending is already set is absorbed, with no counting.
  - wr_done in the same clk as a swap that consumes an earlier pending is consumed by that swap; it does not re-arm pending.
- Only disp_buf is read. wr_buf changes only at a swap.

## Timing
- RAM contract: it samples rd_addr/rd_en at the edge after stage 1 (a new_pxl=0 cycle), and rd_data is stable by the following new_pxl edge.
- Latency: colour and sync outputs for pixel (c,r) appear 2 pixel periods (4 clk) after (c,r) first appears on col/row. They are held 2 clk.
- rd_en is high for exactly 2 clk per displayed pixel. It is never high during blanking.
- A 2x scaled pixel reads the same address on 2 consecutive pixel periods and on 2 consecutive lines.
- swap is asserted during the clk after the swap-point edge. The first address using the new buffer is at row 0 of the next frame.

## Test plan
- Reset with rst=0 for 3 clk, mid-frame. Required: all outputs at reset values; vga_hsync=vga_vsync=1; rd_en=0.
- Frame-0 start with RAM model data = pixel index. At (col,row)=(0,0),(1,0),(2,0),(0,1),(0,2): rd_addr = 0,0,1,0,320. Pixel (639,479) -> rd_addr 76799. Colours are checked 4 clk later against the RGB565 bit slices.
- Sync alignment. Required: vga_hsync falls exactly 4 clk after the raw hsync fall (col 656) and stays low for 192 clk. Same 4-clk offset for vga_vsync.
- Blanking. Required: for col>=640 or row>=480, rd_en=0 and colours=0 at the delayed positions.
- Swap. Pulse wr_done at row 100: swap fires at row 480 col 0; disp_buf=1; rd_addr MSB=1 from the next row 0; wr_buf=0. With no wr_done, a following frame produces no swap.
- Corner cases:
  - wr_done in the same clk as the swap-point edge with pending=0: swap occurs.
  - Two wr_done pulses in one frame: exactly one swap.
  - wr_done coincident with a swap consuming an earlier pending: next frame has no swap.

Source files
------------

// File: rtl/vga_fb_display.sv
// Pixel-fetch and colour-output stage behind a 640x480 VGA sync generator.
// Reads a double-buffered 320x240 RGB565 frame buffer through a 1-cycle
// synchronous RAM port, upscales 2x, drives 4-bit VGA colour and delays the
// syncs to stay aligned with the colour. Buffer swaps occur only at the start
// of vertical blanking so the picture never tears.
module vga_fb_display #(
  parameter int   c_img_cols     = 320,
  parameter int   c_img_rows     = 240,
  parameter int   c_line_visible = 480,
  parameter int   c_nb_pix_addr  = 17,
  parameter logic c_synch_act    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     new_pxl,
  input  logic                     visible,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic [9:0]               col,
  input  logic [9:0]               row,
  input  logic                     wr_done,
  input  logic [15:0]              rd_data,
  output logic [c_nb_pix_addr:0]   rd_addr,
  output logic                     rd_en,
  output logic                     wr_buf,
  output logic                     swap,
  output logic [3:0]               vga_red,
  output logic [3:0]               vga_green,
  output logic [3:0]               vga_blue,
  output logic                     vga_hsync,
  output logic                     vga_vsync
);

  localparam logic [9:0] cols_w     = 10'(c_img_cols);
  localparam logic [9:0] rows_w     = 10'(c_img_rows);
  localparam logic [9:0] line_vis_w = 10'(c_line_visible);
  localparam logic [c_nb_pix_addr-1:0] cols_n = c_nb_pix_addr'(c_img_cols);

  // Source-image coordinates: every source pixel covers a 2x2 display block.
  logic [8:0] src_col;
  logic [8:0] src_row;
  assign src_col = col[9:1];
  assign src_row = row[9:1];

  logic [c_nb_pix_addr-1:0] col_ext;
  logic [c_nb_pix_addr-1:0] row_ext;
  assign col_ext = {{(c_nb_pix_addr-9){1'b0}}, src_col};
  assign row_ext = {{(c_nb_pix_addr-9){1'b0}}, src_row};

  // Linear index inside one buffer, wrapping at the index width.
  logic [c_nb_pix_addr-1:0] pix_idx;
  assign pix_idx = row_ext * cols_n + col_ext;

  logic in_img;
  assign in_img = visible
               && ({1'b0, src_col} < cols_w)
               && ({1'b0, src_row} < rows_w);

  // Start of vertical blanking: the only place the display buffer may flip.
  logic swap_pt;
  assign swap_pt = new_pxl && (row == line_vis_w) && (col == 10'd0);

  // The RGB565 LSBs are dropped when narrowing to 4 bits per channel, and the
  // pixel LSBs of col/row only select the duplicate within a 2x2 block.
  logic unused_bits;
  assign unused_bits = ^{rd_data[11], rd_data[6:5], rd_data[0], col[0], row[0]};

  logic disp_buf;
  logic pending;

  assign wr_buf = ~disp_buf;

  // Buffer control: latch frame-complete events and flip the display buffer at the swap point.
  always_ff @(posedge clk) begin
    if (!rst) begin
      disp_buf <= 1'b0;
      pending  <= 1'b0;
      swap     <= 1'b0;
    end else begin
      swap <= 1'b0;
      if (swap_pt && (pending || wr_done)) begin
        // A wr_done arriving with this swap is consumed by it.
        disp_buf <= ~disp_buf;
        pending  <= 1'b0;
        swap     <= 1'b1;
      end else if (wr_done) begin
        pending <= 1'b1;
      end
    end
  end

  // ---- stage p1: issue RAM read, capture syncs and image-valid flag ----
  logic vld_p1;
  logic hsync_p1;
  logic vsync_p1;

  // Stage 1: address generation and sync/valid delay, advancing on pixel strobes only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      vld_p1   <= 1'b0;
      hsync_p1 <= ~c_synch_act;
      vsync_p1 <= ~c_synch_act;
    end else if (new_pxl) begin
      rd_addr  <= {disp_buf, pix_idx};
      rd_en    <= in_img;
      vld_p1   <= in_img;
      hsync_p1 <= hsync;
      vsync_p1 <= vsync;
    end
  end

  // ---- stage p2: RAM data returned, drive colour and aligned syncs ----
  // Stage 2: convert RGB565 to 4-bit channels, blank outside the image.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_red   <= 4'd0;
      vga_green <= 4'd0;
      vga_blue  <= 4'd0;
      vga_hsync <= ~c_synch_act;
      vga_vsync <= ~c_synch_act;
    end else if (new_pxl) begin
      if (vld_p1) begin
        vga_red   <= rd_data[15:12];
        vga_green <= rd_data[10:7];
        vga_blue  <= rd_data[4:1];
      end else begin
        vga_red   <= 4'd0;
        vga_green <= 4'd0;
        vga_blue  <= 4'd0;
      end
      vga_hsync <= hsync_p1;
      vga_vsync <= vsync_p1;
    end
  end

endmodule
